// File: rtl/sdf_r2_stage.sv
// Radix-2 SDF DIF butterfly stage: buffers half a frame, then emits (a+b)/2 and, one frame later, (a-b)/2.
// Latency: one cycle from the accepting in_valid edge to out_valid; DRAIN emits one difference per cycle.
// Backpressure: none downstream; in_valid gaps stall the stage without loss. SDF_ROUND_EN selects round-half-up halving.
module sdf_r2_stage #(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_re,
  input  logic [DW-1:0]    in_im,
  output logic             out_valid,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic             out_half,
  output logic [CNT_W-1:0] out_idx,
  output logic             busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  // Clamp bounds for the halved result; only the rounded a-b corner can exceed MAXV.
  localparam logic signed [DW+1:0] MAXV = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] MINV = {3'b111, {(DW-1){1'b0}}};
  localparam logic signed [DW+1:0] RND  = {{(DW+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BFLY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pending, pending_nxt;

  // Delay line holds {re, im}; the sample counter doubles as the circular pointer
  // because every frame half starts at slot 0.
  logic [2*DW-1:0]  dly_mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [DW-1:0]    a_re, a_im;

  logic             wr_en;
  logic [2*DW-1:0]  wr_dat;
  logic             emit;
  logic             emit_half;
  logic [DW-1:0]    emit_re, emit_im;

  logic [DW-1:0]    sum_re, sum_im, dif_re, dif_im;

  assign ptr          = cnt[PW-1:0];
  assign {a_re, a_im} = dly_mem[ptr];
  assign busy         = (state != IDLE);

  function automatic logic signed [DW+1:0] sext(input logic [DW-1:0] v);
    return {{2{v[DW-1]}}, v};
  endfunction

  // Halve a widened sum/difference back to DW bits; two guard bits keep the
  // optional rounding increment from wrapping.
  function automatic logic [DW-1:0] halve(input logic signed [DW+1:0] v);
    logic signed [DW+1:0] t;
    logic [DW-1:0]        r;
`ifdef SDF_ROUND_EN
    t = (v + RND) >>> 1;
`else
    t = v >>> 1;
`endif
    if (t > MAXV)
      r = MAXV[DW-1:0];
    else if (t < MINV)
      r = MINV[DW-1:0];
    else
      r = t[DW-1:0];
    return r;
  endfunction

  // Butterfly datapath: a is the buffered first-half sample, b the live input.
  always_comb begin
    sum_re = halve(sext(a_re) + sext(in_re));
    sum_im = halve(sext(a_im) + sext(in_im));
    dif_re = halve(sext(a_re) - sext(in_re));
    dif_im = halve(sext(a_im) - sext(in_im));
  end

  // Next-state, counter, delay-write and emission decisions.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    wr_en       = 1'b0;
    wr_dat      = {in_re, in_im};
    emit        = 1'b0;
    emit_half   = 1'b0;
    emit_re     = a_re;
    emit_im     = a_im;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = FILL;
          cnt_nxt     = '0;
          pending_nxt = 1'b0;
        end
      end

      FILL: begin
        if (pending && (cnt == '0) && flush) begin
          // Stream ends: flush takes priority and any coincident sample is dropped.
          state_nxt = DRAIN;
        end else if (in_valid) begin
          wr_en = 1'b1;
          if (pending) begin
            // Previous frame's difference leaves as the new sample takes its slot.
            emit      = 1'b1;
            emit_half = 1'b1;
          end
          if (cnt == LAST) begin
            state_nxt   = BFLY;
            cnt_nxt     = '0;
            pending_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end

      BFLY: begin
        if (in_valid) begin
          wr_en     = 1'b1;
          wr_dat    = {dif_re, dif_im};
          emit      = 1'b1;
          emit_half = 1'b0;
          emit_re   = sum_re;
          emit_im   = sum_im;
          if (cnt == LAST) begin
            state_nxt   = FILL;
            cnt_nxt     = '0;
            pending_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end

      DRAIN: begin
        emit      = 1'b1;
        emit_half = 1'b1;
        if (cnt == LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          pending_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        pending_nxt = 1'b0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
    end
  end

  // Delay-line write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      dly_mem[ptr] <= wr_dat;
  end

  // Registered outputs; data fields hold their last value when nothing is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_half  <= 1'b0;
      out_idx   <= '0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_re   <= emit_re;
        out_im   <= emit_im;
        out_half <= emit_half;
        out_idx  <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Directed bench for sdf_r2_stage at DEPTH=4, DW=16.
// Frames with hand-computed sums/differences: single, back-to-back, stalled, boundary, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_sdf_r2_stage;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_re = '0;
  logic [DW-1:0]    in_im = '0;
  logic             out_valid;
  logic [DW-1:0]    out_re;
  logic [DW-1:0]    out_im;
  logic             out_half;
  logic [CNT_W-1:0] out_idx;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Single frame: x = 8,4,2,0 | 0,2,4,6
  int sf_x[8] = '{8, 4, 2, 0, 0, 2, 4, 6};
  int sf_s[4] = '{4, 3, 3, 3};
  int sf_d[4] = '{4, 1, -1, -3};

  // Back-to-back frame A: re 10,20,30,40 | 2,4,6,8 ; im -4,0,4,8 | 0,0,0,0
  int a_re[8] = '{10, 20, 30, 40, 2, 4, 6, 8};
  int a_im[8] = '{-4, 0, 4, 8, 0, 0, 0, 0};
  int a_sr[4] = '{6, 12, 18, 24};
  int a_si[4] = '{-2, 0, 2, 4};
  int a_dr[4] = '{4, 8, 12, 16};
  int a_di[4] = '{-2, 0, 2, 4};

  // Boundary frame: a = -32768, 32767, 3, -3 ; b = -32768, -32768, 0, 0 (im = re)
  int bd_x[8] = '{-32768, 32767, 3, -3, -32768, -32768, 0, 0};
`ifdef SDF_ROUND_EN
  int bd_s[4] = '{-32768, 0, 2, -1};
  int bd_d[4] = '{0, 32767, 2, -1};
`else
  int bd_s[4] = '{-32768, -1, 1, -2};
  int bd_d[4] = '{0, 32767, 1, -2};
`endif

  sdf_r2_stage #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .in_valid (in_valid),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_half (out_half),
    .out_idx  (out_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge take them, then settle for sampling.
  task automatic drive(input logic s, input logic f, input logic v, input int re, input int im);
    start    = s;
    flush    = f;
    in_valid = v;
    in_re    = re[DW-1:0];
    in_im    = im[DW-1:0];
    @(posedge clk);
    #1;
    start    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic h, input int idx,
                            input int re, input int im);
    check({tag, ".vld"}, int'(out_valid), int'(v));
    if (v) begin
      check({tag, ".half"}, int'(out_half), int'(h));
      check({tag, ".idx"}, int'(out_idx), idx);
      check({tag, ".re"}, int'($signed(out_re)), re);
      check({tag, ".im"}, int'($signed(out_im)), im);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.vld", int'(out_valid), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.re", int'($signed(out_re)), 0);
    check("rst.idx", int'(out_idx), 0);
    rst = 1'b0;
    drive(0, 0, 1, 77, 0);
    expect_out("idle.ign", 0, 0, 0, 0, 0);
    check("idle.busy", int'(busy), 0);

    // ---------------- single frame + drain
    drive(1, 0, 0, 0, 0);
    check("sf.busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, sf_x[i], 0);
      expect_out("sf.fill", 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, sf_x[4+i], 0);
      expect_out("sf.sum", 1, 0, i, sf_s[i], 0);
    end
    drive(0, 1, 0, 0, 0);
    expect_out("sf.flush", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      expect_out("sf.drain", 1, 1, i, sf_d[i], 0);
    end
    check("sf.busy_end", int'(busy), 0);
    drive(0, 0, 0, 0, 0);
    expect_out("sf.after", 0, 0, 0, 0, 0);
    check("sf.hold_re", int'($signed(out_re)), -3);
    check("sf.hold_idx", int'(out_idx), 3);

    // ---------------- back-to-back frames, ignored start/flush
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(i == 1, 0, 1, a_re[i], a_im[i]);
      expect_out("bb.fillA", 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, a_re[4+i], a_im[4+i]);
      expect_out("bb.sumA", 1, 0, i, a_sr[i], a_si[i]);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, i == 1, 1, 1, 0);
      expect_out("bb.difA", 1, 1, i, a_dr[i], a_di[i]);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 3, 0);
      expect_out("bb.sumB", 1, 0, i, 2, 0);
    end
    drive(0, 1, 0, 0, 0);
    expect_out("bb.flush", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      expect_out("bb.difB", 1, 1, i, -1, 0);
    end

    // ---------------- stalled frame, flush beats a coincident sample
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, sf_x[i], 0);
      if (i < 4)
        expect_out("st.fill", 0, 0, 0, 0, 0);
      else
        expect_out("st.sum", 1, 0, i - 4, sf_s[i-4], 0);
      drive(0, 0, 0, 99, 99);
      expect_out("st.gap", 0, 0, 0, 0, 0);
      if (i >= 4)
        check("st.hold", int'($signed(out_re)), sf_s[i-4]);
    end
    drive(0, 1, 1, 100, 100);
    expect_out("st.flush", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, i[0], 55, 55);
      expect_out("st.drain", 1, 1, i, sf_d[i], 0);
    end

    // ---------------- numeric boundaries (im mirrors re)
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, bd_x[i], bd_x[i]);
      expect_out("bd.fill", 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, bd_x[4+i], bd_x[4+i]);
      expect_out("bd.sum", 1, 0, i, bd_s[i], bd_s[i]);
    end
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      expect_out("bd.diff", 1, 1, i, bd_d[i], bd_d[i]);
    end

    // ---------------- reset in the middle of BFLY
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 2 * (i + 1), 0);
    drive(0, 0, 1, 0, 0);
    expect_out("mr.sum0", 1, 0, 0, 1, 0);
    in_valid = 1'b1;
    in_re    = 16'd6;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check("mr.vld", int'(out_valid), 0);
    check("mr.busy", int'(busy), 0);
    check("mr.re", int'($signed(out_re)), 0);
    in_valid = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, i == 1, 1, 9, 9);
      expect_out("mr.idle", 0, 0, 0, 0, 0);
      check("mr.idle_busy", int'(busy), 0);
    end
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 10, 0);
      expect_out("mr.nostale", 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0);
      expect_out("mr.sum", 1, 0, i, 5, 0);
    end
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      expect_out("mr.drain", 1, 1, i, 5, 0);
    end
    check("mr.busy_end", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
